// File: rtl/less_than_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : less_than_unit                                             |
// | Description : Temporal (race-logic) less-than primitive. The output q    |
// |               carries the a event only when a arrives strictly before b. |
// |               Once b has been seen, a is inhibited until rst re-arms it. |
// |               Optional macro LESS_THAN_TIE_PASS_EN turns the compare     |
// |               into less-or-equal: a and b events in one sample pass.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module less_than_unit #(
  parameter logic [1:0] EDGE_MODE   = 2'd0,  // 0 rise, 1 fall, 2 one-cycle pulse
  parameter int         SYNC_STAGES = 0      // 0..3 flops ahead of edge detection
) (
  input  logic aclk,
  input  logic grst,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic q
);

  // Falling-edge encoding idles high; rise and pulse encodings idle low.
  localparam logic IDLE   = (EDGE_MODE == 2'd1);
  localparam logic PULSE  = (EDGE_MODE == 2'd2);
  localparam logic PASS_Q = ~IDLE;

  logic a_s;
  logic b_s;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] a_sync_q;
      logic [SYNC_STAGES-1:0] b_sync_q;

      // Plain shift chain; the last stage feeds edge detection.
      always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
          a_sync_q <= {SYNC_STAGES{IDLE}};
          b_sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
          a_sync_q[0] <= a;
          b_sync_q[0] <= b;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            a_sync_q[i] <= a_sync_q[i-1];
            b_sync_q[i] <= b_sync_q[i-1];
          end
        end
      end

      assign a_s = a_sync_q[SYNC_STAGES-1];
      assign b_s = b_sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign a_s = a;
      assign b_s = b;
    end
  endgenerate

  logic a_prev_q;
  logic b_prev_q;
  logic b_seen_q;
  logic b_seen_d;
  logic fired_q;
  logic fired_d;
  logic q_q;
  logic q_d;
  logic ev_a;
  logic ev_b;
  logic pass;

  // Edge detection against the previous sample; pulse mode uses the leading edge.
  always_comb begin
    if (EDGE_MODE == 2'd1) begin
      ev_a = ~a_s & a_prev_q;
      ev_b = ~b_s & b_prev_q;
    end else begin
      ev_a = a_s & ~a_prev_q;
      ev_b = b_s & ~b_prev_q;
    end
  end

`ifdef LESS_THAN_TIE_PASS_EN
  // Less-or-equal: a simultaneous b does not inhibit a.
  assign pass = ev_a & ~b_seen_q & ~fired_q;
`else
  // Strict less-than: a simultaneous b inhibits a.
  assign pass = ev_a & ~b_seen_q & ~ev_b & ~fired_q;
`endif

  // Next-state for the wave state and the output; rst overrides any event.
  always_comb begin
    b_seen_d = b_seen_q;
    fired_d  = fired_q;
    q_d      = q_q;
    if (rst) begin
      b_seen_d = 1'b0;
      fired_d  = 1'b0;
      q_d      = IDLE;
    end else begin
      if (PULSE) begin
        q_d = 1'b0;
      end
      if (ev_b) begin
        b_seen_d = 1'b1;
      end
      if (pass) begin
        fired_d = 1'b1;
        q_d     = PASS_Q;
      end
    end
  end

  // State registers; previous samples always track so a held level never
  // looks like a fresh event after rst.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      a_prev_q <= IDLE;
      b_prev_q <= IDLE;
      b_seen_q <= 1'b0;
      fired_q  <= 1'b0;
      q_q      <= IDLE;
    end else begin
      a_prev_q <= a_s;
      b_prev_q <= b_s;
      b_seen_q <= b_seen_d;
      fired_q  <= fired_d;
      q_q      <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: tb/tb_less_than_unit.sv
`default_nettype none

module tb_less_than_unit;

  typedef struct {
    logic rst;
    logic a;
    logic b;
    logic q;
  } vec_t;

`ifdef LESS_THAN_TIE_PASS_EN
  localparam logic TIE_Q = 1'b1;
`else
  localparam logic TIE_Q = 1'b0;
`endif

  logic clk = 1'b0;
  logic grst;
  logic rst;
  logic a0, b0, a1, b1, a2, b2;
  logic q0, q1, q2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  less_than_unit #(.EDGE_MODE(2'd0), .SYNC_STAGES(0)) u_rise (
    .aclk(clk), .grst(grst), .rst(rst), .a(a0), .b(b0), .q(q0));
  less_than_unit #(.EDGE_MODE(2'd1), .SYNC_STAGES(0)) u_fall (
    .aclk(clk), .grst(grst), .rst(rst), .a(a1), .b(b1), .q(q1));
  less_than_unit #(.EDGE_MODE(2'd2), .SYNC_STAGES(2)) u_pulse (
    .aclk(clk), .grst(grst), .rst(rst), .a(a2), .b(b2), .q(q2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  vec_t rise_tab[19];
  vec_t fall_tab[9];
  int   pulses;

  initial begin
    // rise mode: rst, a, b, expected q after the edge
    rise_tab = '{
      '{1'b1, 1'b0, 1'b0, 1'b0},  // rst
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},  // a first -> pass, same-edge latency
      '{1'b0, 1'b1, 1'b1, 1'b1},  // b after pass: no effect
      '{1'b0, 1'b0, 1'b0, 1'b1},  // held until rst
      '{1'b0, 1'b1, 1'b0, 1'b1},  // second a ignored
      '{1'b1, 1'b1, 1'b1, 1'b0},  // rst with levels high
      '{1'b0, 1'b1, 1'b1, 1'b0},  // held level is not an event
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0},  // b first
      '{1'b0, 1'b1, 1'b1, 1'b0},  // a after b: inhibited
      '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, TIE_Q}, // same-sample tie
      '{1'b0, 1'b1, 1'b1, TIE_Q},
      '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1},  // re-armed
      '{1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0},  // edge during rst is not detected
      '{1'b0, 1'b1, 1'b0, 1'b0}   // and not seen afterwards
    };
    // fall mode
    fall_tab = '{
      '{1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0},  // a falls first -> q falls
      '{1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0},  // held until rst
      '{1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1},  // b falls first
      '{1'b0, 1'b0, 1'b0, 1'b1},  // a after b: q stays idle
      '{1'b0, 1'b0, 1'b0, 1'b1}
    };

    grst = 1'b0; rst = 1'b0;
    a0 = 1'b0; b0 = 1'b0; a1 = 1'b1; b1 = 1'b1; a2 = 1'b0; b2 = 1'b0;
    repeat (3) tick();
    chk("reset_rise_q", q0, 1'b0);
    chk("reset_fall_q", q1, 1'b1);
    chk("reset_pulse_q", q2, 1'b0);
    #3 grst = 1'b1;

    // No events: q stays idle
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("idle_rise_q", q0, 1'b0);
    end

    for (int i = 0; i < 19; i++) begin
      rst = rise_tab[i].rst; a0 = rise_tab[i].a; b0 = rise_tab[i].b;
      tick();
      chk($sformatf("rise_vec%0d", i), q0, rise_tab[i].q);
    end
    rst = 1'b0; a0 = 1'b0; b0 = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rst = fall_tab[i].rst; a1 = fall_tab[i].a; b1 = fall_tab[i].b;
      tick();
      chk($sformatf("fall_vec%0d", i), q1, fall_tab[i].q);
    end
    rst = 1'b0;

    // Pulse mode with two sync stages: 3-cycle a pulse then a b pulse
    a2 = 1'b0; b2 = 1'b0;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    tick();
    pulses = 0;
    a2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) a2 = 1'b0;
      if (c == 4) b2 = 1'b1;
      if (c == 5) b2 = 1'b0;
      chk($sformatf("pulse_cyc%0d", c), q2, (c == 3) ? 1'b1 : 1'b0);
      if (q2 === 1'b1) pulses++;
    end
    chk("pulse_count_is_one", (pulses == 1) ? 1'b1 : 1'b0, 1'b1);

    // grst mid-pulse clears q asynchronously
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    tick();
    a2 = 1'b1;
    tick(); tick(); tick();
    chk("pulse_before_grst", q2, 1'b1);
    #2 grst = 1'b0;
    #1;
    chk("grst_async_pulse_q", q2, 1'b0);
    chk("grst_async_fall_q", q1, 1'b1);
    chk("grst_async_rise_q", q0, 1'b0);
    a2 = 1'b0;
    tick();
    #3 grst = 1'b1;
    repeat (6) begin
      tick();
      chk("after_grst_pulse_q", q2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
